uart_frame_scheduler: RTL

UART_FRAME_SCHEDULER -- requirements
Module: uart_frame_scheduler

---
 rtl/uart_frame_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_scheduler
// Description : Round-robin arbiter that lets NUM_SRC requesters share one
//               byte-wide UART transmitter. Each grant sends a 7-byte ASCII
//               frame: source tag, four uppercase hex digits, CR, LF.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_scheduler #(
    parameter int         NUM_SRC  = 3,
    parameter logic [7:0] TAG_BASE = 8'h41
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    req,
    input  logic [NUM_SRC*16-1:0] data_in,
    output logic [NUM_SRC-1:0]    ack,
    input  logic                  tx_ready,
    output logic                  tx_start,
    output logic [7:0]            tx_byte,
    output logic                  busy,
    output logic [1:0]            grant_id
);

    localparam logic [2:0] C_FRAME_BYTES = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q,   ptr_d;
    logic [1:0]  grant_q, grant_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [15:0] data_q,  data_d;
    logic        busy_q,  busy_d;

    logic [1:0]  winner;
    logic        any_req;
    logic [1:0]  idx;
    logic        hit;
    logic [15:0] sel_data;
    logic [7:0]  cur_byte;

    // Next source index with wrap-around at NUM_SRC.
    function automatic logic [1:0] wrap_inc(input logic [1:0] v);
        return (int'(v) + 1 >= NUM_SRC) ? 2'd0 : v + 2'd1;
    endfunction

    // Uppercase ASCII for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Round-robin search starting at ptr, first requesting source wins.
    always_comb begin
        any_req = 1'b0;
        winner  = ptr_q;
        idx     = ptr_q;
        hit     = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            hit = 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (idx == 2'(i)) begin
                    hit = req[i];
                end
            end
            if (!any_req && hit) begin
                any_req = 1'b1;
                winner  = idx;
            end
            idx = wrap_inc(idx);
        end
    end

    // Select the granted source's data word for latching.
    always_comb begin
        sel_data = 16'h0000;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 2'(i)) begin
                sel_data = data_in[16*i +: 16];
            end
        end
    end

    // Frame byte addressed by the byte counter.
    always_comb begin
        cur_byte = 8'h0A;
        case (cnt_q)
            3'd0:    cur_byte = TAG_BASE + {6'b0, grant_q};
            3'd1:    cur_byte = hex_ascii(data_q[15:12]);
            3'd2:    cur_byte = hex_ascii(data_q[11:8]);
            3'd3:    cur_byte = hex_ascii(data_q[7:4]);
            3'd4:    cur_byte = hex_ascii(data_q[3:0]);
            3'd5:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    // Frame sequencing: next state, datapath updates and strobe outputs.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        busy_d   = busy_q;
        tx_start = 1'b0;
        tx_byte  = 8'h00;
        ack      = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_d  = sel_data;
                cnt_d   = 3'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_start = 1'b1;
                    tx_byte  = cur_byte;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Released as soon as the transmitter reports ready again.
                if (tx_ready) begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_d < C_FRAME_BYTES) ? ST_SEND : ST_DONE;
                end
            end
            ST_DONE: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant_q == 2'(i)) begin
                        ack[i] = 1'b1;
                    end
                end
                ptr_d   = wrap_inc(grant_q);
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Strobes are held quiet for the whole reset window, not just after it.
        if (reset) begin
            tx_start = 1'b0;
            tx_byte  = 8'h00;
            ack      = '0;
        end
    end

    assign busy     = busy_q & ~reset;
    assign grant_id = reset ? 2'd0 : grant_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            grant_q <= 2'd0;
            cnt_q   <= 3'd0;
            data_q  <= 16'h0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

endmodule
`default_nettype wire
